// File: rtl/square_sweep_unit.sv
// Frequency-sweep engine for the square-wave channel: a shadow frequency is
// stepped on 128 Hz ticks through a writeback/re-check state machine with overflow disable.
module square_sweep_unit #(
    parameter int FREQ_W   = 11,
    parameter int SHIFT_W  = 3,
    parameter int PERIOD_W = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                tick_128,
    input  logic                trigger,
    input  logic [PERIOD_W-1:0] sweep_period,
    input  logic                sweep_negate,
    input  logic [SHIFT_W-1:0]  sweep_shift,
    input  logic                freq_wr,
    input  logic [FREQ_W-1:0]   freq_in,
    output logic [FREQ_W-1:0]   freq_out,
    output logic                freq_load,
    output logic                channel_enable,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, CHECK, CALC1, CALC2} state_t;

    state_t              state;
    logic [FREQ_W-1:0]   shadow;
    logic [PERIOD_W:0]   timer;
    logic [PERIOD_W:0]   reload;
    logic [FREQ_W:0]     delta;
    logic [FREQ_W:0]     calc;
    logic                overflow;
    logic                expired;
    logic                sweep_en;
    logic                negate_used;

    // A period field of zero behaves as the longest period, 2^PERIOD_W ticks.
    always_comb begin
        reload           = '0;
        reload[PERIOD_W] = 1'b1;
        if (sweep_period != '0)
            reload = {1'b0, sweep_period};
    end

    // The top bit of calc flags overflow; a subtraction can never set it.
    always_comb begin
        delta    = {1'b0, shadow >> sweep_shift};
        calc     = sweep_negate ? ({1'b0, shadow} - delta) : ({1'b0, shadow} + delta);
        overflow = calc[FREQ_W];
        expired  = (timer[PERIOD_W:1] == '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            shadow         <= '0;
            timer          <= '0;
            sweep_en       <= 1'b0;
            negate_used    <= 1'b0;
            freq_out       <= '0;
            freq_load      <= 1'b0;
            channel_enable <= 1'b0;
            busy           <= 1'b0;
        end else begin
            freq_load <= 1'b0;
            if (trigger) begin
                shadow         <= freq_wr ? freq_in : freq_out;
                timer          <= reload;
                sweep_en       <= (sweep_period != '0) || (sweep_shift != '0);
                negate_used    <= 1'b0;
                channel_enable <= 1'b1;
                state          <= (sweep_shift != '0) ? CHECK : IDLE;
                busy           <= (sweep_shift != '0);
            end else begin
                if (tick_128)
                    timer <= expired ? reload : timer - (PERIOD_W+1)'(1);

                case (state)
                    IDLE: begin
                        if (tick_128 && expired && sweep_en && sweep_period != '0) begin
                            state <= CALC1;
                            busy  <= 1'b1;
                        end
                    end
                    CALC1: begin
                        if (sweep_negate)
                            negate_used <= 1'b1;
                        if (overflow) begin
                            channel_enable <= 1'b0;
                            state          <= IDLE;
                            busy           <= 1'b0;
                        end else begin
                            if (sweep_shift != '0) begin
                                shadow    <= calc[FREQ_W-1:0];
                                freq_out  <= calc[FREQ_W-1:0];
                                freq_load <= 1'b1;
                            end
                            state <= CALC2;
                        end
                    end
                    default: begin
                        // CHECK and CALC2 share the check-only behaviour.
                        if (sweep_negate)
                            negate_used <= 1'b1;
                        if (overflow)
                            channel_enable <= 1'b0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase

                if (!sweep_negate && negate_used)
                    channel_enable <= 1'b0;
            end

            // A CPU write overrides a coincident sweep writeback on freq_out.
            if (freq_wr)
                freq_out <= freq_in;
        end
    end

endmodule

// File: tb/tb_square_sweep_unit.sv
// Directed self-checking bench for square_sweep_unit: inputs driven and outputs
// sampled on the falling edge, with hand-computed expectations.
module tb_square_sweep_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick_128 = 1'b0;
    logic        trigger = 1'b0;
    logic [2:0]  sweep_period = '0;
    logic        sweep_negate = 1'b0;
    logic [2:0]  sweep_shift = '0;
    logic        freq_wr = 1'b0;
    logic [10:0] freq_in = '0;
    logic [10:0] freq_out;
    logic        freq_load;
    logic        channel_enable;
    logic        busy;

    int total = 0;
    int bad = 0;

    square_sweep_unit #(.FREQ_W(11), .SHIFT_W(3), .PERIOD_W(3)) dut (
        .clock(clock), .reset_n(reset_n), .tick_128(tick_128), .trigger(trigger),
        .sweep_period(sweep_period), .sweep_negate(sweep_negate), .sweep_shift(sweep_shift),
        .freq_wr(freq_wr), .freq_in(freq_in), .freq_out(freq_out), .freq_load(freq_load),
        .channel_enable(channel_enable), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        {tick_128, trigger, freq_wr, sweep_negate} = '0;
        sweep_period = '0;
        sweep_shift = '0;
        freq_in = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic write_freq(input logic [10:0] f);
        freq_in = f;
        freq_wr = 1'b1;
        @(negedge clock);
        freq_wr = 1'b0;
    endtask

    // Trigger, then let the CHECK cycle (if any) complete.
    task automatic do_trigger();
        trigger = 1'b1;
        @(negedge clock);
        trigger = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    // One tick followed by enough idle cycles for a full CALC sequence.
    task automatic do_tick(output int loads, output int busies);
        loads = 0;
        busies = 0;
        tick_128 = 1'b1;
        @(negedge clock);
        tick_128 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            loads += int'(freq_load);
            busies += int'(busy);
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        int loads, busies;
        apply_reset();
        total++; if (freq_out !== 11'h000) begin bad++; $display("[TB] FAIL reset_freq_out got=%h want=000", freq_out); end
        total++; if (freq_load !== 1'b0) begin bad++; $display("[TB] FAIL reset_freq_load got=%b want=0", freq_load); end
        total++; if (channel_enable !== 1'b0) begin bad++; $display("[TB] FAIL reset_enable got=%b want=0", channel_enable); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        sweep_period = 3'd1;
        sweep_shift = 3'd1;
        do_tick(loads, busies);
        total++; if (busies !== 0) begin bad++; $display("[TB] FAIL first_tick_busy got=%0d want=0", busies); end
        total++; if (loads !== 0) begin bad++; $display("[TB] FAIL first_tick_loads got=%0d want=0", loads); end
    endtask

    task automatic test_trigger_check();
        apply_reset();
        write_freq(11'h700);
        sweep_shift = 3'd1;
        trigger = 1'b1;
        @(negedge clock);
        trigger = 1'b0;
        total++; if (channel_enable !== 1'b1) begin bad++; $display("[TB] FAIL trig_enable_e0 got=%b want=1", channel_enable); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL trig_busy_e0 got=%b want=1", busy); end
        @(negedge clock);
        total++; if (channel_enable !== 1'b0) begin bad++; $display("[TB] FAIL trig_enable_e1 got=%b want=0", channel_enable); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL trig_busy_e1 got=%b want=0", busy); end
        total++; if (freq_load !== 1'b0) begin bad++; $display("[TB] FAIL trig_load got=%b want=0", freq_load); end
        total++; if (freq_out !== 11'h700) begin bad++; $display("[TB] FAIL trig_freq got=%h want=700", freq_out); end
    endtask

    task automatic test_two_step();
        apply_reset();
        write_freq(11'h400);
        sweep_period = 3'd1;
        sweep_shift = 3'd1;
        do_trigger();
        total++; if (channel_enable !== 1'b1) begin bad++; $display("[TB] FAIL two_enable_pre got=%b want=1", channel_enable); end
        tick_128 = 1'b1;
        @(negedge clock);
        tick_128 = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL two_busy_e0 got=%b want=1", busy); end
        total++; if (freq_out !== 11'h400) begin bad++; $display("[TB] FAIL two_freq_e0 got=%h want=400", freq_out); end
        @(negedge clock);
        total++; if (freq_out !== 11'h600) begin bad++; $display("[TB] FAIL two_freq_e1 got=%h want=600", freq_out); end
        total++; if (freq_load !== 1'b1) begin bad++; $display("[TB] FAIL two_load_e1 got=%b want=1", freq_load); end
        total++; if (channel_enable !== 1'b1) begin bad++; $display("[TB] FAIL two_enable_e1 got=%b want=1", channel_enable); end
        @(negedge clock);
        total++; if (channel_enable !== 1'b0) begin bad++; $display("[TB] FAIL two_enable_e2 got=%b want=0", channel_enable); end
        total++; if (freq_load !== 1'b0) begin bad++; $display("[TB] FAIL two_load_e2 got=%b want=0", freq_load); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL two_busy_e2 got=%b want=0", busy); end
    endtask

    task automatic setup_decrease();
        apply_reset();
        write_freq(11'h100);
        sweep_period = 3'd2;
        sweep_shift = 3'd2;
        sweep_negate = 1'b1;
        do_trigger();
    endtask

    task automatic test_decrease();
        int loads, busies, sum;
        setup_decrease();
        sum = 0;
        do_tick(loads, busies); sum += loads;
        do_tick(loads, busies); sum += loads;
        total++; if (freq_out !== 11'h0C0) begin bad++; $display("[TB] FAIL dec_freq_1 got=%h want=0c0", freq_out); end
        do_tick(loads, busies); sum += loads;
        do_tick(loads, busies); sum += loads;
        total++; if (freq_out !== 11'h090) begin bad++; $display("[TB] FAIL dec_freq_2 got=%h want=090", freq_out); end
        total++; if (sum !== 2) begin bad++; $display("[TB] FAIL dec_loads got=%0d want=2", sum); end
        total++; if (channel_enable !== 1'b1) begin bad++; $display("[TB] FAIL dec_enable got=%b want=1", channel_enable); end
    endtask

    task automatic test_period_zero();
        int loads, busies, sum_l, sum_b;
        apply_reset();
        write_freq(11'h200);
        sweep_period = 3'd0;
        sweep_shift = 3'd3;
        do_trigger();
        sum_l = 0;
        sum_b = 0;
        for (int t = 0; t < 16; t++) begin
            do_tick(loads, busies);
            sum_l += loads;
            sum_b += busies;
        end
        total++; if (sum_l !== 0) begin bad++; $display("[TB] FAIL p0_loads got=%0d want=0", sum_l); end
        total++; if (sum_b !== 0) begin bad++; $display("[TB] FAIL p0_busy got=%0d want=0", sum_b); end
        total++; if (freq_out !== 11'h200) begin bad++; $display("[TB] FAIL p0_freq got=%h want=200", freq_out); end
        total++; if (channel_enable !== 1'b1) begin bad++; $display("[TB] FAIL p0_enable got=%b want=1", channel_enable); end
    endtask

    task automatic test_negate_clear();
        int loads, busies;
        setup_decrease();
        do_tick(loads, busies);
        do_tick(loads, busies);
        total++; if (channel_enable !== 1'b1) begin bad++; $display("[TB] FAIL nc_enable_pre got=%b want=1", channel_enable); end
        sweep_negate = 1'b0;
        @(negedge clock);
        total++; if (channel_enable !== 1'b0) begin bad++; $display("[TB] FAIL nc_enable_post got=%b want=0", channel_enable); end
    endtask

    task automatic test_abort();
        apply_reset();
        write_freq(11'h400);
        sweep_period = 3'd1;
        sweep_shift = 3'd1;
        do_trigger();
        tick_128 = 1'b1;
        @(negedge clock);
        tick_128 = 1'b0;
        reset_n = 1'b0;
        #1;
        total++; if (freq_out !== 11'h000) begin bad++; $display("[TB] FAIL rst_mid_freq got=%h want=000", freq_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_busy got=%b want=0", busy); end
        total++; if (channel_enable !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_enable got=%b want=0", channel_enable); end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        total++; if (freq_load !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_load got=%b want=0", freq_load); end

        write_freq(11'h400);
        do_trigger();
        tick_128 = 1'b1;
        @(negedge clock);
        tick_128 = 1'b0;
        @(negedge clock);
        // Now in CALC2 with a pending overflow; retrigger with a new frequency.
        trigger = 1'b1;
        freq_wr = 1'b1;
        freq_in = 11'h100;
        @(negedge clock);
        trigger = 1'b0;
        freq_wr = 1'b0;
        total++; if (channel_enable !== 1'b1) begin bad++; $display("[TB] FAIL abort_enable got=%b want=1", channel_enable); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL abort_busy got=%b want=1", busy); end
        total++; if (freq_out !== 11'h100) begin bad++; $display("[TB] FAIL abort_freq got=%h want=100", freq_out); end
        @(negedge clock);
        total++; if (channel_enable !== 1'b1) begin bad++; $display("[TB] FAIL abort_check_enable got=%b want=1", channel_enable); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_check_busy got=%b want=0", busy); end
    endtask

    initial begin
        test_reset();
        test_trigger_check();
        test_two_step();
        test_decrease();
        test_period_zero();
        test_negate_clear();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
